// File: rtl/switch_counter_pkg.sv
// ----------------------------------------------------------------------------
// switch_counter_pkg
// Shared constants for the switch-gated prescaled counter.
//   DIR_UP / DIR_DOWN   : encodings of the dir input
//   MODE_WRAP / MODE_SAT: encodings of the sat input
//   *_DEF               : default parameter values for the top and sub-module
// ----------------------------------------------------------------------------
package switch_counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int WIDTH_DEF      = 8;
    localparam int PRESCALE_DEF   = 1;
    localparam int DEB_CYCLES_DEF = 4;

endpackage : switch_counter_pkg

// File: rtl/sw_debounce.sv
// ----------------------------------------------------------------------------
// sw_debounce
// Two-flop synchroniser on the raw switch followed by an optional debounce
// filter. The filtered level only follows the synchronised switch once it has
// held a new value for DEB_CYCLES consecutive clocks.
//
// Build option: SWITCH_COUNTER_DEBOUNCE_EN
//   defined   -> debounce counter active (latency 2+DEB_CYCLES edges)
//   undefined -> no filter, sw_db follows the synchroniser (latency 3 edges)
//
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   sw    in  raw switch, asynchronous to clk
//   sw_db out debounced switch level, registered
// ----------------------------------------------------------------------------
module sw_debounce
    import switch_counter_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic sw_db
);

    if (DEB_CYCLES < 1) begin : g_bad_deb
        $error("sw_debounce: DEB_CYCLES must be >= 1");
    end

    logic s1_q, s2_q;
    logic db_q, db_d;

    // Plain synchroniser; s2_q is the first clean copy of sw.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sw;
            s2_q <= s1_q;
        end
    end

`ifdef SWITCH_COUNTER_DEBOUNCE_EN
    // Counter wide enough to hold DEB_CYCLES-1 even when DEB_CYCLES is 1.
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Any return of s2 to the current filtered level restarts the count,
    // so a glitch shorter than DEB_CYCLES never reaches db_q.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end
`else
    always_comb begin
        db_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_q <= 1'b0;
        end else begin
            db_q <= db_d;
        end
    end
`endif

    assign sw_db = db_q;

endmodule : sw_debounce

// File: rtl/switch_counter.sv
// ----------------------------------------------------------------------------
// switch_counter
// Switch-enabled prescaled up/down counter. The raw switch is synchronised and
// (optionally) debounced in sw_debounce; the debounced level enables a
// prescaler whose tick advances the count. The count wraps or saturates at
// 0 / MAX_VAL and emits a one-cycle terminal-count pulse on each tick taken at
// the terminal value. A synchronous load overrides counting.
//
// Build option: SWITCH_COUNTER_DEBOUNCE_EN (honoured inside sw_debounce).
//
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset, overrides everything
//   sw       in  raw switch, asynchronous to clk
//   dir      in  0 = count up, 1 = count down (sampled on tick only)
//   sat      in  0 = wrap, 1 = saturate (sampled on tick only)
//   load     in  synchronous load strobe
//   load_val in  value to load, clamped to MAX_VAL
//   count    out current count, registered
//   tc       out terminal-count pulse, registered
//   sw_db    out debounced switch level, registered
// ----------------------------------------------------------------------------
module switch_counter
    import switch_counter_pkg::*;
#(
    parameter int          WIDTH      = WIDTH_DEF,
    parameter int unsigned MAX_VAL    = (2 ** WIDTH) - 1,
    parameter int          PRESCALE   = PRESCALE_DEF,
    parameter int          DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw,
    input  logic             dir,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             sw_db
);

    if (PRESCALE < 1) begin : g_bad_psc
        $error("switch_counter: PRESCALE must be >= 1");
    end
    if (MAX_VAL < 1) begin : g_bad_max
        $error("switch_counter: MAX_VAL must be >= 1");
    end

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam int               PW    = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0]    PSC_LAST = PW'(PRESCALE - 1);

    logic             en;
    logic             tick;
    logic [PW-1:0]    psc_q, psc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    sw_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk   (clk),
        .rst   (rst),
        .sw    (sw),
        .sw_db (en)
    );

    // With PRESCALE=1 psc_q stays 0 and tick reduces to en.
    assign tick = en && (psc_q == PSC_LAST);

    always_comb begin
        count_d = count_q;
        psc_d   = psc_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_C) ? MAX_C : load_val;
            psc_d   = '0;
        end else begin
            if (!en || tick) begin
                psc_d = '0;
            end else begin
                psc_d = psc_q + PW'(1);
            end
            // dir/sat only matter here, so mid-prescale changes are harmless.
            if (tick) begin
                if (dir == DIR_UP) begin
                    if (count_q == MAX_C) begin
                        tc_d    = 1'b1;
                        count_d = (sat == MODE_SAT) ? count_q : '0;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        tc_d    = 1'b1;
                        count_d = (sat == MODE_SAT) ? count_q : MAX_C;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            psc_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            psc_q   <= psc_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign sw_db = en;

endmodule : switch_counter

// File: tb/tb_switch_counter.sv
// ----------------------------------------------------------------------------
// tb_switch_counter
// Directed bench for switch_counter. Three instances share the stimulus:
//   u0: WIDTH=8, PRESCALE=1 (reset, debounce, wrap, saturate)
//   u1: WIDTH=8, PRESCALE=3 (prescale, hold, reset mid-run)
//   u2: WIDTH=4, MAX_VAL=9  (load clamp and priority, small-range wrap)
// ----------------------------------------------------------------------------
module tb_switch_counter;

    localparam int DEB = 4;
`ifdef SWITCH_COUNTER_DEBOUNCE_EN
    localparam int LAT = 2 + DEB;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rst, sw, dir, sat, load;
    logic [7:0] load_val;

    logic [7:0] count0, count1;
    logic [3:0] count2;
    logic       tc0, tc1, tc2;
    logic       swdb0, swdb1, swdb2;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    switch_counter #(.WIDTH(8), .PRESCALE(1), .DEB_CYCLES(DEB)) u0 (
        .clk(clk), .rst(rst), .sw(sw), .dir(dir), .sat(sat), .load(load),
        .load_val(load_val), .count(count0), .tc(tc0), .sw_db(swdb0));

    switch_counter #(.WIDTH(8), .PRESCALE(3), .DEB_CYCLES(DEB)) u1 (
        .clk(clk), .rst(rst), .sw(sw), .dir(dir), .sat(sat), .load(load),
        .load_val(load_val), .count(count1), .tc(tc1), .sw_db(swdb1));

    switch_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .DEB_CYCLES(DEB)) u2 (
        .clk(clk), .rst(rst), .sw(sw), .dir(dir), .sat(sat), .load(load),
        .load_val(load_val[3:0]), .count(count2), .tc(tc2), .sw_db(swdb2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with sw and load active.
        rst = 1'b1; sw = 1'b1; load = 1'b1; load_val = 8'h55;
        dir = 1'b0; sat = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_count", 32'(count0), 32'h0);
            chk("rst_tc", 32'(tc0), 32'h0);
            chk("rst_swdb", 32'(swdb0), 32'h0);
        end
        rst = 1'b0; load = 1'b0;
        for (int e = 1; e <= LAT; e++) begin
            step();
            chk("rise_lat", 32'(swdb0), 32'(e == LAT));
        end

        // Drop sw and let sw_db settle low.
        sw = 1'b0;
        for (int e = 1; e <= LAT + 2; e++) step();
        chk("fall_settle", 32'(swdb0), 32'h0);

        // Three-cycle glitch.
        sw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 3) sw = 1'b0;
`ifdef SWITCH_COUNTER_DEBOUNCE_EN
            chk("glitch", 32'(swdb0), 32'h0);
`else
            chk("glitch", 32'(swdb0), 32'(e >= 3 && e <= 5));
`endif
        end

        // Stable high.
        sw = 1'b1;
        for (int e = 1; e <= LAT; e++) begin
            step();
            chk("stable_lat", 32'(swdb0), 32'(e == LAT));
        end

        // Up wrap on u0: FE -> FF -> 00 (tc) -> 01.
        load = 1'b1; load_val = 8'hFE; dir = 1'b0; sat = 1'b0;
        step();
        chk("upw_load", 32'(count0), 32'hFE);
        chk("upw_load_tc", 32'(tc0), 32'h0);
        load = 1'b0;
        step(); chk("upw_c1", 32'(count0), 32'hFF); chk("upw_t1", 32'(tc0), 32'h0);
        step(); chk("upw_c2", 32'(count0), 32'h00); chk("upw_t2", 32'(tc0), 32'h1);
        step(); chk("upw_c3", 32'(count0), 32'h01); chk("upw_t3", 32'(tc0), 32'h0);

        // Down saturate on u0: 2 -> 1,0,0,0 with tc 0,0,1,1.
        load = 1'b1; load_val = 8'h02; dir = 1'b1; sat = 1'b1;
        step();
        chk("dns_load", 32'(count0), 32'h02);
        load = 1'b0;
        step(); chk("dns_c1", 32'(count0), 32'h1); chk("dns_t1", 32'(tc0), 32'h0);
        step(); chk("dns_c2", 32'(count0), 32'h0); chk("dns_t2", 32'(tc0), 32'h0);
        step(); chk("dns_c3", 32'(count0), 32'h0); chk("dns_t3", 32'(tc0), 32'h1);
        step(); chk("dns_c4", 32'(count0), 32'h0); chk("dns_t4", 32'(tc0), 32'h1);

        // Prescale on u1: step every third edge after a load of 0.
        load = 1'b1; load_val = 8'h00; dir = 1'b0; sat = 1'b0;
        step();
        chk("psc_load", 32'(count1), 32'h0);
        load = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk("psc_step", 32'(count1), 32'(e / 3));
        end

        // Drop sw: ticks continue until sw_db falls, then count holds.
        sw = 1'b0;
        for (int e = 1; e <= LAT; e++) step();
        chk("hold_swdb", 32'(swdb1), 32'h0);
        chk("hold_cnt0", 32'(count1), 32'(2 + LAT / 3));
        for (int e = 1; e <= 6; e++) step();
        chk("hold_cnt1", 32'(count1), 32'(2 + LAT / 3));
        chk("hold_tc", 32'(tc1), 32'h0);

        // Re-enable, let it run, then reset mid-run.
        sw = 1'b1;
        for (int e = 1; e <= LAT + 2; e++) step();
        chk("rerun_swdb", 32'(swdb1), 32'h1);
        rst = 1'b1;
        step();
        chk("midrst_cnt", 32'(count1), 32'h0);
        chk("midrst_tc", 32'(tc1), 32'h0);
        chk("midrst_swdb", 32'(swdb1), 32'h0);
        rst = 1'b0;
        for (int e = 1; e <= LAT + 1; e++) step();
        chk("u2_swdb", 32'(swdb2), 32'h1);

        // Load clamp on u2 coincident with a tick: 12 -> 9, tc 0.
        load = 1'b1; load_val = 8'h0C; dir = 1'b0; sat = 1'b0;
        step();
        chk("ldp_cnt", 32'(count2), 32'h9);
        chk("ldp_tc", 32'(tc2), 32'h0);
        load = 1'b0;
        step();
        chk("ldp_wrap_cnt", 32'(count2), 32'h0);
        chk("ldp_wrap_tc", 32'(tc2), 32'h1);
        // Down from 0 wraps to MAX_VAL with tc.
        dir = 1'b1;
        step();
        chk("dnw_cnt", 32'(count2), 32'h9);
        chk("dnw_tc", 32'(tc2), 32'h1);
        step();
        chk("dnw_cnt2", 32'(count2), 32'h8);
        chk("dnw_tc2", 32'(tc2), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule : tb_switch_counter
